bus_master_bidder: RTL and testbench



---
 rtl/bidder_pkg.sv | 32 +++
 rtl/bidder_fifo.sv | 47 ++++
 rtl/bus_master_bidder.sv | 173 +++++++++++++++++
 tb/tb_bus_master_bidder.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bidder_pkg.sv
// Shared types for the bus master bidder: FSM states, command bundle
// and the per-master slave address map check.
package bidder_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BID  = 2'd1,
      S_XFER = 2'd2,
      S_RESP = 2'd3
   } state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic        rw;
      logic [31:0] wdata;
      logic [3:0]  bid;
   } cmd_t;

   localparam logic [31:0] ADDR_BASE = 32'hFFEF_0200;
   // Slave nibble may only take 0..3, so bits 13:12 are don't-care.
   localparam logic [31:0] ADDR_MASK = 32'hFFFF_CFFF;

   function automatic logic addr_legal(
      input logic [31:0] a,
      input logic [1:0]  mid
   );
      logic [31:0] exp;
      exp = ADDR_BASE | {24'h0, 2'b00, mid, 4'h0};
      return (a & ADDR_MASK) == exp;
   endfunction

endpackage

// File: rtl/bidder_fifo.sv
// Synchronous command FIFO for the bidder; flushed by reset.
// Pushes when full and pops when empty are ignored.
module bidder_fifo
   import bidder_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic pop,
   input  cmd_t wdata,
   output cmd_t rdata,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   cmd_t        mem [DEPTH];
   logic [AW:0] wp;
   logic [AW:0] rp;
   logic        do_wr;
   logic        do_rd;

   assign do_wr = push && !full;
   assign do_rd = pop && !empty;
   assign empty = (wp == rp);
   assign full  = (wp[AW] != rp[AW]) &&
                  (wp[AW-1:0] == rp[AW-1:0]);
   assign rdata = mem[rp[AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_wr) wp <= wp + 1'b1;
         if (do_rd) rp <= rp + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wp[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/bus_master_bidder.sv
// Master-side bid front end: command FIFO, bid budget, grant handshake.
// Optional BIDDER_ESCALATE_EN raises the bid on grant timeout.
module bus_master_bidder
   import bidder_pkg::*;
#(
   parameter int MASTER_ID  = 0,
   parameter int FIFO_DEPTH = 4,
   parameter int AMT        = 10,
   parameter int MAX_CLK    = 16,
   parameter int MAX_AMT    = 150,
   parameter int WAIT_MAX   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_addr,
   input  logic        cmd_rw,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_bid,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [3:0]  req,
   output logic [31:0] addr,
   output logic        RW,
   output logic [31:0] DataToSlave,
   input  logic        grant,
   input  logic [31:0] DataFromSlave
);

   localparam int RCW = $clog2(MAX_CLK + 1);
   localparam int WCW = $clog2(WAIT_MAX + 1);

   state_t         state;
   cmd_t           in_cmd;
   cmd_t           head;
   logic           full;
   logic           empty;
   logic           pop;
   logic [31:0]    addr_q;
   logic [31:0]    wdata_q;
   logic [31:0]    rdata_q;
   logic           rw_q;
   logic           err_q;
   logic [3:0]     bid_q;
   logic [7:0]     budget;
   logic [RCW-1:0] rep_cnt;
   logic [WCW-1:0] wait_cnt;
   logic [3:0]     iss;
   logic           take;
   logic           tmo;
   logic           wrap;
   logic [8:0]     sum;
   logic [7:0]     refill;
   logic [7:0]     budget_n;

   always_comb begin
      in_cmd       = '0;
      in_cmd.addr  = cmd_addr;
      in_cmd.rw    = cmd_rw;
      in_cmd.wdata = cmd_wdata;
      in_cmd.bid   = cmd_bid;
   end

   assign pop       = (state == S_IDLE) && !empty;
   assign cmd_ready = !full;

   bidder_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cmd_valid),
      .pop   (pop),
      .wdata (in_cmd),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   // A zero budget yields a zero issued bid, i.e. no request.
   always_comb begin
      iss = (budget < {4'h0, bid_q}) ? budget[3:0] : bid_q;
      take = (state == S_BID) && (budget != 8'h0) && grant;
      tmo = (state == S_BID) && (budget != 8'h0) && !grant &&
            (wait_cnt == WCW'(WAIT_MAX - 1));
      wrap = (rep_cnt == RCW'(MAX_CLK - 1));
      sum = {1'b0, budget} + 9'(AMT);
      refill = budget;
      if (wrap)
         refill = (sum > 9'(MAX_AMT)) ? 8'(MAX_AMT) : sum[7:0];
      budget_n = refill;
      if (take)
         budget_n = (refill > {4'h0, iss}) ?
                    refill - {4'h0, iss} : 8'h0;
   end

`ifdef BIDDER_ESCALATE_EN
   logic [3:0] sat_lim;
   assign sat_lim = (budget > 8'd15) ? 4'd15 : budget[3:0];
`endif

   assign req         = (state == S_BID) ? iss : 4'h0;
   assign rsp_valid   = (state == S_RESP);
   assign rsp_err     = rsp_valid && err_q;
   assign rsp_rdata   = rsp_valid ? rdata_q : 32'h0;
   assign addr        = addr_q;
   assign RW          = rw_q;
   assign DataToSlave = wdata_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         rw_q     <= 1'b0;
         err_q    <= 1'b0;
         bid_q    <= '0;
         budget   <= 8'(AMT);
         rep_cnt  <= '0;
         wait_cnt <= '0;
      end else begin
         budget  <= budget_n;
         rep_cnt <= wrap ? '0 : rep_cnt + 1'b1;
         unique case (state)
            S_IDLE: begin
               if (!empty) begin
                  rdata_q <= '0;
                  if (addr_legal(head.addr, 2'(MASTER_ID))) begin
                     addr_q   <= head.addr;
                     rw_q     <= head.rw;
                     wdata_q  <= head.wdata;
                     bid_q    <= (head.bid == 4'h0) ? 4'h1 : head.bid;
                     wait_cnt <= '0;
                     err_q    <= 1'b0;
                     state    <= S_BID;
                  end else begin
                     err_q <= 1'b1;
                     state <= S_RESP;
                  end
               end
            end
            S_BID: begin
               if (take) begin
                  rdata_q <= rw_q ? 32'h0 : DataFromSlave;
                  state   <= S_XFER;
               end else if (tmo) begin
`ifdef BIDDER_ESCALATE_EN
                  if (bid_q >= sat_lim) begin
                     err_q <= 1'b1;
                     state <= S_RESP;
                  end else begin
                     bid_q    <= bid_q + 4'd1;
                     wait_cnt <= '0;
                  end
`else
                  err_q <= 1'b1;
                  state <= S_RESP;
`endif
               end else if (budget != 8'h0) begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_XFER: state <= S_RESP;
            S_RESP: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_master_bidder.sv
// Directed bench for bus_master_bidder with MASTER_ID = 1.
// Cycle numbers count clock edges since reset release.
module tb_bus_master_bidder;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_addr;
   logic        cmd_rw;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_bid;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [3:0]  req;
   logic [31:0] addr;
   logic        RW;
   logic [31:0] DataToSlave;
   logic        grant;
   logic [31:0] DataFromSlave;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   bus_master_bidder #(
      .MASTER_ID  (1),
      .FIFO_DEPTH (4),
      .AMT        (10),
      .MAX_CLK    (16),
      .MAX_AMT    (150),
      .WAIT_MAX   (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_addr      (cmd_addr),
      .cmd_rw        (cmd_rw),
      .cmd_wdata     (cmd_wdata),
      .cmd_bid       (cmd_bid),
      .rsp_valid     (rsp_valid),
      .rsp_rdata     (rsp_rdata),
      .rsp_err       (rsp_err),
      .req           (req),
      .addr          (addr),
      .RW            (RW),
      .DataToSlave   (DataToSlave),
      .grant         (grant),
      .DataFromSlave (DataFromSlave)
   );

   task tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task run_to(input int n);
      while (cyc < n) tick();
   endtask

   task do_reset();
      cmd_valid = 1'b0;
      cmd_addr = '0;
      cmd_rw = 1'b0;
      cmd_wdata = '0;
      cmd_bid = '0;
      grant = 1'b0;
      DataFromSlave = '0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      cyc = 0;
   endtask

   task push_cmd(input logic [31:0] a, input logic rw,
                 input logic [31:0] d, input logic [3:0] b);
      cmd_valid = 1'b1;
      cmd_addr = a;
      cmd_rw = rw;
      cmd_wdata = d;
      cmd_bid = b;
   endtask

   task test_reset();
      rst = 1'b0;
      #2;
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready);
      end
      checks++;
      if ({rsp_valid, rsp_err, RW, req} !== 7'h0) begin
         failures++;
         $display("FAIL rst_ctrl got=%b%b%b req=%0d exp=0",
                  rsp_valid, rsp_err, RW, req);
      end
      checks++;
      if ({addr, DataToSlave, rsp_rdata} !== 96'h0) begin
         failures++;
         $display("FAIL rst_data got=%h %h %h exp=0",
                  addr, DataToSlave, rsp_rdata);
      end
      do_reset();
      checks++;
      if (dut.budget !== 8'd10) begin
         failures++;
         $display("FAIL rst_budget got=%0d exp=10", dut.budget);
      end
   endtask

   task test_write();
      do_reset();
      grant = 1'b1;
      push_cmd(32'hFFEF_1210, 1'b1, 32'h1234_5678, 4'd5);
      tick();
      cmd_valid = 1'b0;
      checks++;
      if (req !== 4'd0) begin
         failures++;
         $display("FAIL wr_req_early got=%0d exp=0", req);
      end
      tick();
      checks++;
      if (req !== 4'd5) begin
         failures++;
         $display("FAIL wr_req got=%0d exp=5", req);
      end
      checks++;
      if ({addr, RW, DataToSlave} !== {32'hFFEF_1210, 1'b1, 32'h1234_5678})
      begin
         failures++;
         $display("FAIL wr_bus got=%h %b %h exp=ffef1210 1 12345678",
                  addr, RW, DataToSlave);
      end
      tick();
      checks++;
      if (req !== 4'd0 || dut.budget !== 8'd5) begin
         failures++;
         $display("FAIL wr_xfer got req=%0d budget=%0d exp=0 5",
                  req, dut.budget);
      end
      tick();
      checks++;
      if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h0) begin
         failures++;
         $display("FAIL wr_rsp got=%b%b %h exp=10 0",
                  rsp_valid, rsp_err, rsp_rdata);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL wr_rsp_pulse got=%b exp=0", rsp_valid);
      end
      grant = 1'b0;
   endtask

   task test_read();
      do_reset();
      grant = 1'b1;
      DataFromSlave = 32'hA5A5_0001;
      push_cmd(32'hFFEF_2210, 1'b0, 32'h0, 4'd2);
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      DataFromSlave = 32'hDEAD_BEEF;
      grant = 1'b0;
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 ||
          rsp_rdata !== 32'hA5A5_0001) begin
         failures++;
         $display("FAIL rd_rsp got=%b%b %h exp=10 a5a50001",
                  rsp_valid, rsp_err, rsp_rdata);
      end
   endtask

   task test_illegal();
      do_reset();
      grant = 1'b1;
      push_cmd(32'hFFEF_2200, 1'b1, 32'h5, 4'd4);
      tick();
      cmd_valid = 1'b0;
      checks++;
      if (req !== 4'd0) begin
         failures++;
         $display("FAIL ill_req1 got=%0d exp=0", req);
      end
      tick();
      checks++;
      if ({rsp_valid, rsp_err} !== 2'b11 || req !== 4'd0) begin
         failures++;
         $display("FAIL ill_rsp got=%b%b req=%0d exp=11 0",
                  rsp_valid, rsp_err, req);
      end
      checks++;
      if (addr !== 32'h0) begin
         failures++;
         $display("FAIL ill_addr got=%h exp=0", addr);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || req !== 4'd0) begin
         failures++;
         $display("FAIL ill_after got=%b req=%0d exp=0 0",
                  rsp_valid, req);
      end
      grant = 1'b0;
   endtask

   task test_timeout();
      do_reset();
      push_cmd(32'hFFEF_0210, 1'b1, 32'h9, 4'd5);
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (req !== 4'd5 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL to_wait%0d got req=%0d rsp=%b exp=5 0",
                     i, req, rsp_valid);
         end
      end
      tick();
`ifdef BIDDER_ESCALATE_EN
      checks++;
      if (req !== 4'd6 || rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL to_esc6 got req=%0d rsp=%b exp=6 0",
                  req, rsp_valid);
      end
      run_to(18);
      checks++;
      if (req !== 4'd7) begin
         failures++;
         $display("FAIL to_esc7 got req=%0d exp=7", req);
      end
`else
      checks++;
      if ({rsp_valid, rsp_err} !== 2'b11 || req !== 4'd0) begin
         failures++;
         $display("FAIL to_err got=%b%b req=%0d exp=11 0",
                  rsp_valid, rsp_err, req);
      end
`endif
   endtask

   task test_budget_zero();
      do_reset();
      grant = 1'b1;
      push_cmd(32'hFFEF_0210, 1'b1, 32'h1, 4'd10);
      tick();
      cmd_valid = 1'b0;
      tick();
      checks++;
      if (req !== 4'd10) begin
         failures++;
         $display("FAIL bz_req10 got=%0d exp=10", req);
      end
      tick();
      checks++;
      if (dut.budget !== 8'd0) begin
         failures++;
         $display("FAIL bz_budget0 got=%0d exp=0", dut.budget);
      end
      push_cmd(32'hFFEF_3210, 1'b1, 32'h2, 4'd3);
      tick();
      cmd_valid = 1'b0;
      run_to(6);
      checks++;
      if (req !== 4'd0) begin
         failures++;
         $display("FAIL bz_stall6 got=%0d exp=0", req);
      end
      run_to(15);
      checks++;
      if (req !== 4'd0 || rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL bz_stall15 got req=%0d rsp=%b exp=0 0",
                  req, rsp_valid);
      end
      tick();
      checks++;
      if (req !== 4'd3) begin
         failures++;
         $display("FAIL bz_refill got=%0d exp=3", req);
      end
      tick();
      checks++;
      if (dut.budget !== 8'd7) begin
         failures++;
         $display("FAIL bz_debit got=%0d exp=7", dut.budget);
      end
      grant = 1'b0;
   endtask

   task test_saturate();
      do_reset();
      grant = 1'b1;
      push_cmd(32'hFFEF_1210, 1'b1, 32'h3, 4'd5);
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      grant = 1'b0;
      run_to(223);
      checks++;
      if (dut.budget !== 8'd135) begin
         failures++;
         $display("FAIL sat_135 got=%0d exp=135", dut.budget);
      end
      run_to(224);
      checks++;
      if (dut.budget !== 8'd145) begin
         failures++;
         $display("FAIL sat_145 got=%0d exp=145", dut.budget);
      end
      run_to(240);
      checks++;
      if (dut.budget !== 8'd150) begin
         failures++;
         $display("FAIL sat_150 got=%0d exp=150", dut.budget);
      end
      run_to(256);
      checks++;
      if (dut.budget !== 8'd150) begin
         failures++;
         $display("FAIL sat_hold got=%0d exp=150", dut.budget);
      end
   endtask

   task test_back_to_back();
      do_reset();
      grant = 1'b1;
      DataFromSlave = 32'h0000_BEEF;
      push_cmd(32'hFFEF_0210, 1'b1, 32'h1, 4'd2);
      tick();
      push_cmd(32'hFFEF_3210, 1'b0, 32'h0, 4'd0);
      tick();
      cmd_valid = 1'b0;
      checks++;
      if (req !== 4'd2 || addr !== 32'hFFEF_0210) begin
         failures++;
         $display("FAIL b2b_a got req=%0d addr=%h exp=2 ffef0210",
                  req, addr);
      end
      run_to(6);
      checks++;
      if (req !== 4'd1 || addr !== 32'hFFEF_3210 || RW !== 1'b0) begin
         failures++;
         $display("FAIL b2b_b got req=%0d addr=%h rw=%b exp=1 ffef3210 0",
                  req, addr, RW);
      end
      tick();
      checks++;
      if (dut.budget !== 8'd7) begin
         failures++;
         $display("FAIL b2b_budget got=%0d exp=7", dut.budget);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_BEEF) begin
         failures++;
         $display("FAIL b2b_rsp got=%b %h exp=1 0000beef",
                  rsp_valid, rsp_rdata);
      end
      grant = 1'b0;
   endtask

   task test_fifo_full_reset();
      do_reset();
      push_cmd(32'hFFEF_1210, 1'b1, 32'h7, 4'd5);
      tick();
      cmd_valid = 1'b0;
      tick();
      push_cmd(32'hFFEF_2210, 1'b1, 32'h8, 4'd1);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (cmd_ready !== (i < 4)) begin
            failures++;
            $display("FAIL ff_ready%0d got=%b exp=%b",
                     i, cmd_ready, (i < 4));
         end
         tick();
      end
      cmd_valid = 1'b0;
      checks++;
      if (req !== 4'd5) begin
         failures++;
         $display("FAIL ff_bid got=%0d exp=5", req);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (req !== 4'd0 || cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL ff_rst got req=%0d ready=%b exp=0 1",
                  req, cmd_ready);
      end
      tick();
      rst = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if (rsp_valid !== 1'b0 || req !== 4'd0) begin
            failures++;
            $display("FAIL ff_quiet%0d got rsp=%b req=%0d exp=0 0",
                     i, rsp_valid, req);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_illegal();
      test_timeout();
      test_budget_zero();
      test_saturate();
      test_back_to_back();
      test_fifo_full_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
